// File: rtl/i2s_tx_pkg.sv
// Shared types and helpers for the I2S master transmitter.
// Word-select encoding and slot decoding live here.
package i2s_tx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  // WS leads the data by one bit, so it flips on each slot's last bit
  function automatic logic ws_for_k(input int k, input int dw);
    return (k >= dw - 1 && k <= 2 * dw - 2) ? WS_RIGHT : WS_LEFT;
  endfunction

endpackage

// File: rtl/i2s_tx_clkgen.sv
// Bit-clock divider: SCK half-period of CLK_DIV clk_i cycles.
// Strobes mark the clk_i edge on which SCK rises or falls.
module i2s_tx_clkgen
  import i2s_tx_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_q, div_d;
  logic          sck_q, sck_d;
  logic          tick;

  assign tick   = run_i && (div_q == DIV_LAST);
  assign rise_o = tick & ~sck_q;
  assign fall_o = tick & sck_q;
  assign sck_o  = sck_q;

  always_comb begin
    div_d = div_q;
    sck_d = sck_q;
    if (!run_i) begin
      div_d = '0;
      sck_d = 1'b0;
    end else if (tick) begin
      div_d = '0;
      sck_d = ~sck_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/i2s_tx_master.sv
// Philips-format I2S master transmitter with a one-entry
// stereo holding buffer; sends silence on underrun.
module i2s_tx_master
  import i2s_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] sample_left_i,
  input  logic [DATA_WIDTH-1:0] sample_right_i,
  input  logic                  sample_valid_i,
  output logic                  sample_ready_o,
  output logic                  i2s_sck_o,
  output logic                  i2s_ws_o,
  output logic                  i2s_sd_o,
  output logic                  busy_o,
  output logic                  underrun_o
);

  localparam int FW = 2 * DATA_WIDTH;
  localparam int BW = $clog2(FW);
  localparam logic [BW-1:0] K_LAST = BW'(FW - 1);

  state_e                state_q, state_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
  logic [FW-1:0]         shift_q, shift_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  ws_q, ws_d;
  logic                  sd_q, sd_d;
  logic                  und_q, und_d;

  logic          run;
  logic          sck;
  logic          sck_fall;
  logic          sck_rise_unused;
  logic          accept;
  logic [BW-1:0] k_next;
  logic [FW-1:0] frame;

  assign run    = (state_q == RUN);
  assign accept = sample_valid_i & ~hold_valid_q;
  assign k_next = (bit_cnt_q == K_LAST) ? '0 : bit_cnt_q + 1'b1;

  i2s_tx_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .run_i (run),
    .sck_o (sck),
    .rise_o(sck_rise_unused),
    .fall_o(sck_fall)
  );

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_l_d     = hold_l_q;
    hold_r_d     = hold_r_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    ws_d         = ws_q;
    sd_d         = sd_q;
    und_d        = 1'b0;
    frame        = shift_q;
    unique case (state_q)
      IDLE: begin
        if (en_i) state_d = RUN;
      end
      RUN: begin
        if (sck_fall) begin
          if (k_next == '0 && !en_i) begin
            state_d   = IDLE;
            bit_cnt_d = K_LAST;
            ws_d      = WS_LEFT;
            sd_d      = 1'b0;
          end else begin
            bit_cnt_d = k_next;
            if (k_next == '0) begin
              if (hold_valid_q) begin
                frame        = {hold_l_q, hold_r_q};
                hold_valid_d = 1'b0;
              end else begin
                frame = '0;
                und_d = 1'b1;
              end
              shift_d = frame;
            end
            ws_d = ws_for_k(int'(k_next), DATA_WIDTH);
            sd_d = frame[K_LAST - k_next];
          end
        end
      end
      default: ;
    endcase
    // accept only when empty, so it never collides with a consume
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_l_d     = sample_left_i;
      hold_r_d     = sample_right_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= K_LAST;
      ws_q         <= 1'b0;
      sd_q         <= 1'b0;
      und_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_l_q     <= hold_l_d;
      hold_r_q     <= hold_r_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      ws_q         <= ws_d;
      sd_q         <= sd_d;
      und_q        <= und_d;
    end
  end

  assign sample_ready_o = ~hold_valid_q;
  assign i2s_sck_o      = sck;
  assign i2s_ws_o       = ws_q;
  assign i2s_sd_o       = sd_q;
  assign busy_o         = run;
  assign underrun_o     = und_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Bench for i2s_tx_master: DW=2/CD=1 vector table plus
// DW=16/CD=2 directed sequences against a cycle-arithmetic model.
module tb_i2s_tx_master;

  localparam int DW = 16;
  localparam int CD = 2;
  localparam int FW = 2 * DW;

  logic clk;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_on = 0;

  // instance A: DW=16, CD=2
  logic rst_a = 1'b1;
  logic en_a = 1'b0;
  logic valid_a = 1'b0;
  logic [DW-1:0] l_a = '0, r_a = '0;
  logic ready_a, sck_a, ws_a, sd_a, busy_a, und_a;

  // instance B: DW=2, CD=1
  logic rst_b = 1'b1;
  logic en_b = 1'b0;
  logic valid_b = 1'b0;
  logic [1:0] l_b = '0, r_b = '0;
  logic ready_b, sck_b, ws_b, sd_b, busy_b, und_b;

  i2s_tx_master #(.DATA_WIDTH(DW), .CLK_DIV(CD)) u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .en_i(en_a),
    .sample_left_i(l_a), .sample_right_i(r_a),
    .sample_valid_i(valid_a), .sample_ready_o(ready_a),
    .i2s_sck_o(sck_a), .i2s_ws_o(ws_a), .i2s_sd_o(sd_a),
    .busy_o(busy_a), .underrun_o(und_a)
  );

  i2s_tx_master #(.DATA_WIDTH(2), .CLK_DIV(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .en_i(en_b),
    .sample_left_i(l_b), .sample_right_i(r_b),
    .sample_valid_i(valid_b), .sample_ready_o(ready_b),
    .i2s_sck_o(sck_b), .i2s_ws_o(ws_b), .i2s_sd_o(sd_b),
    .busy_o(busy_b), .underrun_o(und_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: run time n since RUN entry gives SCK by division;
  // every 2*CD cycles a fall advances the bit index k
  bit m_run = 0, m_hv = 0, m_ws = 0, m_sd = 0, m_und = 0, m_acc;
  int m_n = 0;
  int m_k = FW - 1;
  logic [DW-1:0] m_hl = '0, m_hr = '0;
  logic [FW-1:0] m_frame = '0;

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      m_run = 0; m_hv = 0; m_ws = 0; m_sd = 0; m_und = 0;
      m_n = 0; m_k = FW - 1; m_frame = '0;
    end else begin
      m_acc = valid_a && !m_hv;
      m_und = 0;
      if (!m_run) begin
        if (en_a) begin m_run = 1; m_n = 0; end
      end else begin
        m_n++;
        if (m_n % (2 * CD) == 0) begin
          m_k = (m_k + 1) % FW;
          if (m_k == 0 && !en_a) begin
            m_run = 0; m_k = FW - 1; m_ws = 0; m_sd = 0;
          end else begin
            if (m_k == 0) begin
              if (m_hv) begin m_frame = {m_hl, m_hr}; m_hv = 0; end
              else begin m_frame = '0; m_und = 1; end
            end
            m_ws = (m_k >= DW - 1) && (m_k <= FW - 2);
            m_sd = m_frame[FW-1-m_k];
          end
        end
      end
      if (m_acc) begin m_hv = 1; m_hl = l_a; m_hr = r_a; end
    end
  end

  int und_cyc = 0;
  always @(negedge clk) begin
    if (chk_on && !rst_a) begin
      chk("cyc_sck", sck_a, m_run ? (m_n / CD) % 2 : 0);
      chk("cyc_ws", ws_a, m_ws);
      chk("cyc_sd", sd_a, m_sd);
      chk("cyc_und", und_a, m_und);
      chk("cyc_ready", ready_a, !m_hv);
      chk("cyc_busy", busy_a, m_run);
      if (und_a) und_cyc++;
    end
  end

  // wire-level receiver: sample on rising SCK, a WS change ends a word
  int rises = 0;
  logic prev_ws = 1'b0;
  logic [31:0] wacc = '0;
  logic [DW-1:0] cap_q[$];

  always @(posedge sck_a or posedge rst_a) begin
    if (rst_a) begin
      prev_ws = 1'b0; wacc = '0; cap_q.delete();
    end else begin
      rises++;
      wacc = {wacc[30:0], sd_a};
      if (ws_a != prev_ws) cap_q.push_back(wacc[DW-1:0]);
      prev_ws = ws_a;
    end
  end

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
    valid_a = 1'b1; l_a = l; r_a = r;
    for (int i = 0; i < 400 && !ready_a; i++) @(negedge clk);
    chk("push_ready", ready_a, 1);
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int i = 0; i < budget && cap_q.size() < n; i++) @(negedge clk);
    chk("wait_words", cap_q.size(), n);
  endtask

  task automatic wait_k(input int k);
    for (int i = 0; i < 300 && m_k != k; i++) @(negedge clk);
    chk("wait_k", m_k, k);
  endtask

  task automatic first_rise(input string nm);
    int n;
    for (int i = 0; i < 10 && !busy_a; i++) @(negedge clk);
    chk({nm, "_busy"}, busy_a, 1);
    n = 0;
    while (!sck_a && n < 10) begin @(negedge clk); n++; end
    chk({nm, "_first_rise"}, n, CD);
  endtask

  typedef struct {
    logic en, vld;
    logic [1:0] l, r;
    logic sck, ws, sd, und, rdy, bsy;
  } vec_t;
  vec_t tbl[13];

  int acc, dbl, pn, idx;
  int acc_t[10];
  bit prev;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 2'b10, 2'b01, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1};
    tbl[2]  = '{1'b1, 1'b0, 2'b00, 2'b00, 1, 0, 0, 0, 0, 1};
    tbl[3]  = '{1'b1, 1'b0, 2'b00, 2'b00, 0, 0, 1, 0, 1, 1};
    tbl[4]  = '{1'b1, 1'b0, 2'b00, 2'b00, 1, 0, 1, 0, 1, 1};
    tbl[5]  = '{1'b1, 1'b0, 2'b00, 2'b00, 0, 1, 0, 0, 1, 1};
    tbl[6]  = '{1'b1, 1'b0, 2'b00, 2'b00, 1, 1, 0, 0, 1, 1};
    tbl[7]  = '{1'b1, 1'b0, 2'b00, 2'b00, 0, 1, 0, 0, 1, 1};
    tbl[8]  = '{1'b1, 1'b0, 2'b00, 2'b00, 1, 1, 0, 0, 1, 1};
    tbl[9]  = '{1'b1, 1'b0, 2'b00, 2'b00, 0, 0, 1, 0, 1, 1};
    tbl[10] = '{1'b1, 1'b0, 2'b00, 2'b00, 1, 0, 1, 0, 1, 1};
    tbl[11] = '{1'b1, 1'b0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 1};
    tbl[12] = '{1'b1, 1'b0, 2'b00, 2'b00, 1, 0, 0, 0, 1, 1};

    repeat (2) @(negedge clk);
    chk("rst_ready", ready_a, 1);
    chk("rst_sck", sck_a, 0);
    chk("rst_ws", ws_a, 0);
    chk("rst_sd", sd_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_und", und_a, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    chk_on = 1;

    @(negedge clk);
    foreach (tbl[i]) begin
      en_b = tbl[i].en; valid_b = tbl[i].vld;
      l_b = tbl[i].l; r_b = tbl[i].r;
      @(negedge clk);
      chk($sformatf("tbl%0d_sck", i), sck_b, tbl[i].sck);
      chk($sformatf("tbl%0d_ws", i), ws_b, tbl[i].ws);
      chk($sformatf("tbl%0d_sd", i), sd_b, tbl[i].sd);
      chk($sformatf("tbl%0d_und", i), und_b, tbl[i].und);
      chk($sformatf("tbl%0d_rdy", i), ready_b, tbl[i].rdy);
      chk($sformatf("tbl%0d_bsy", i), busy_b, tbl[i].bsy);
    end
    en_b = 1'b0;

    // prefill while idle, then enable
    und_cyc = 0;
    push(16'hA5C3, 16'h0F01);
    chk("pre_ready", ready_a, 0);
    en_a = 1'b1;
    first_rise("t1");
    wait_words(2, 300);
    chk("t1_left", cap_q[0], 16'hA5C3);
    chk("t1_right", cap_q[1], 16'h0F01);
    chk("t1_und", und_cyc, 0);

    // underrun frames
    cap_q.delete(); und_cyc = 0;
    wait_words(4, 400);
    foreach (cap_q[i]) chk("t2_silence", cap_q[i], 0);
    chk("t2_und_cycles", und_cyc, 2);

    // back-pressure: valid held with an incrementing pair
    cap_q.delete();
    valid_a = 1'b1; pn = 0;
    l_a = 16'h1000; r_a = 16'h2000;
    acc = 0; dbl = 0; prev = 0;
    for (int i = 0; i < 1600 && acc < 9; i++) begin
      if (ready_a) begin
        if (prev) dbl++;
        acc_t[acc] = cyc; acc++;
      end
      prev = ready_a;
      @(negedge clk);
      if (prev) begin
        pn++;
        l_a = 16'h1000 + 16'(pn); r_a = 16'h2000 + 16'(pn);
      end
    end
    valid_a = 1'b0;
    chk("bp_accepts", acc, 9);
    chk("bp_ready_double", dbl, 0);
    for (int i = 1; i < 8; i++) chk("bp_interval", acc_t[i+1] - acc_t[i], 128);
    for (int i = 0; i < 300 && !ready_a; i++) @(negedge clk);
    chk("bp_drain", ready_a, 1);

    // graceful stop at k=5
    wait_k(5);
    pn = rises;
    en_a = 1'b0;
    for (int i = 0; i < 300 && busy_a; i++) @(negedge clk);
    chk("stop_bits", rises - pn, 27);
    chk("stop_busy", busy_a, 0);
    chk("stop_sck", sck_a, 0);
    chk("stop_ws", ws_a, 0);
    chk("stop_sd", sd_a, 0);
    idx = 0;
    while (idx < cap_q.size() && cap_q[idx] == 0) idx++;
    chk("bp_words", cap_q.size() - idx, 18);
    for (int n = 0; n < 9; n++) begin
      if (idx + 2 * n + 1 < cap_q.size()) begin
        chk("bp_left", cap_q[idx+2*n], 16'h1000 + n);
        chk("bp_right", cap_q[idx+2*n+1], 16'h2000 + n);
      end
    end
    push(16'hCAFE, 16'hBEEF);
    chk("idle_hold", ready_a, 0);
    chk("idle_busy", busy_a, 0);
    cap_q.delete();
    en_a = 1'b1;
    wait_words(2, 300);
    chk("re_left", cap_q[0], 16'hCAFE);
    chk("re_right", cap_q[1], 16'hBEEF);

    // async reset mid-frame with a pair waiting in the buffer
    wait_k(3);
    push(16'h1234, 16'h5678);
    wait_k(20);
    chk("pre_rst_ready", ready_a, 0);
    chk("pre_rst_ws", ws_a, 1);
    #2;
    rst_a = 1'b1; en_a = 1'b0;
    #1;
    chk("arst_ready", ready_a, 1);
    chk("arst_busy", busy_a, 0);
    chk("arst_sck", sck_a, 0);
    chk("arst_ws", ws_a, 0);
    chk("arst_sd", sd_a, 0);
    chk("arst_und", und_a, 0);
    rst_a = 1'b0;
    @(negedge clk);
    push(16'hABCD, 16'h1357);
    en_a = 1'b1;
    first_rise("t5");
    wait_words(2, 300);
    chk("t5_left", cap_q[0], 16'hABCD);
    chk("t5_right", cap_q[1], 16'h1357);
    en_a = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
